// File: rtl/sd_sector_loader.sv
// sd_sector_loader: streams SD sectors byte-by-byte into 32-bit little-endian words
// and writes them to a word-addressed memory port with valid/ready handshaking.
module sd_sector_loader #(
    parameter int          AddrWidth     = 21,
    parameter int unsigned TimeoutCycles = 16_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [31:0]          start_sector_i,
    input  logic [15:0]          sector_count_i,
    input  logic [AddrWidth-1:0] dest_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [1:0]           sd_cmd_o,
    output logic [31:0]          sd_sector_o,
    input  logic [7:0]           sd_data_i,
    input  logic                 sd_busy_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    output logic                 mem_valid_o,
    input  logic                 mem_ready_i
);
    typedef enum logic [3:0] {
        IDLE, WAIT_CARD, ISSUE_READ, WAIT_RISE, WAIT_READ, FETCH,
        CAPTURE, WRITE, NEXT_SECTOR, DONE, ERROR
    } state_t;

    state_t               r_state, w_next;
    logic [31:0]          r_sector, r_word, r_timer;
    logic [15:0]          r_count;
    logic [AddrWidth-1:0] r_dest;
    logic [8:0]           r_bytes;
    logic                 r_error;
    logic                 w_timeout;

    assign w_timeout   = r_timer == TimeoutCycles - 1;
    assign error_o     = r_error;
    assign sd_sector_o = r_sector;
    assign mem_addr_o  = r_dest;
    assign mem_data_o  = r_word;

    always_comb begin
        w_next      = r_state;
        busy_o      = !(r_state inside {IDLE, DONE, ERROR});
        done_o      = r_state == DONE || r_state == ERROR;
        sd_cmd_o    = r_state == ISSUE_READ ? 2'd1 : r_state == FETCH ? 2'd2 : 2'd0;
        mem_valid_o = r_state == WRITE;
        case (r_state)
            IDLE:        if (start_i) w_next = sector_count_i == 16'd0 ? DONE : WAIT_CARD;
            WAIT_CARD:   w_next = !sd_busy_i ? ISSUE_READ : w_timeout ? ERROR : WAIT_CARD;
            ISSUE_READ:  w_next = WAIT_RISE;
            WAIT_RISE:   w_next = WAIT_READ;
            WAIT_READ:   w_next = !sd_busy_i ? FETCH : w_timeout ? ERROR : WAIT_READ;
            FETCH:       w_next = CAPTURE;
            CAPTURE:     w_next = r_bytes[1:0] == 2'd3 ? WRITE : FETCH;
            // A byte counter back at zero means all 512 bytes of the sector are written
            WRITE:       if (mem_ready_i) w_next = r_bytes == 9'd0 ? NEXT_SECTOR : FETCH;
            NEXT_SECTOR: w_next = r_count == 16'd1 ? DONE : ISSUE_READ;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_sector <= '0;
            r_word   <= '0;
            r_timer  <= '0;
            r_count  <= '0;
            r_dest   <= '0;
            r_bytes  <= '0;
            r_error  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_timer <= (r_state == WAIT_CARD || r_state == WAIT_READ) ? r_timer + 32'd1 : '0;
            if (r_state == IDLE && start_i && sector_count_i != 16'd0) begin
                r_sector <= start_sector_i;
                r_count  <= sector_count_i;
                r_dest   <= dest_addr_i;
                r_error  <= 1'b0;
            end
            if (w_next == ERROR)
                r_error <= 1'b1;
            if (r_state == WAIT_READ)
                r_bytes <= '0;
            if (r_state == CAPTURE) begin
                r_word  <= {sd_data_i, r_word[31:8]};
                r_bytes <= r_bytes + 9'd1;
            end
            if (r_state == WRITE && mem_ready_i)
                r_dest <= r_dest + AddrWidth'(1);
            if (r_state == NEXT_SECTOR) begin
                r_count  <= r_count - 16'd1;
                r_sector <= r_sector + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_sd_sector_loader.sv
// tb_sd_sector_loader: directed bench with a behavioural SD block (bytes i%256 per sector)
// and a memory sink that can stall one chosen write.
module tb_sd_sector_loader;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] start_sector_i;
    logic [15:0] sector_count_i;
    logic [20:0] dest_addr_i;
    logic        busy_o, done_o, error_o, mem_valid_o, mem_ready_i, sd_busy_i;
    logic [1:0]  sd_cmd_o;
    logic [31:0] sd_sector_o, mem_data_o;
    logic [7:0]  sd_data_i;
    logic [20:0] mem_addr_o;

    int checks = 0;
    int failures = 0;

    sd_sector_loader #(.AddrWidth(21), .TimeoutCycles(100)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .start_sector_i(start_sector_i),
        .sector_count_i(sector_count_i), .dest_addr_i(dest_addr_i), .busy_o(busy_o),
        .done_o(done_o), .error_o(error_o), .sd_cmd_o(sd_cmd_o), .sd_sector_o(sd_sector_o),
        .sd_data_i(sd_data_i), .sd_busy_i(sd_busy_i), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int         busy_cnt = 0;
    logic [8:0] byte_idx = '0;
    logic       stuck;
    always @(posedge clk_i) begin
        if (rst_i) begin
            busy_cnt  <= 6;
            byte_idx  <= '0;
            sd_data_i <= '0;
        end else begin
            if (sd_cmd_o == 2'd1) begin
                busy_cnt <= 20;
                byte_idx <= '0;
            end else if (busy_cnt > 0)
                busy_cnt <= busy_cnt - 1;
            if (sd_cmd_o == 2'd2) begin
                sd_data_i <= byte_idx[7:0];
                byte_idx  <= byte_idx + 9'd1;
            end
        end
    end
    assign sd_busy_i = stuck || busy_cnt != 0;

    logic [20:0] addr_q[$];
    logic [31:0] data_q[$];
    logic [31:0] sec_q[$];
    int n_writes = 0, n_done = 0, n_cmd = 0, stall_cnt = 0, stall_at = -1;
    logic stall_en;
    assign mem_ready_i = !(stall_en && mem_valid_o && n_writes == stall_at && stall_cnt < 10);
    always @(posedge clk_i) begin
        if (mem_valid_o && mem_ready_i) begin
            addr_q.push_back(mem_addr_o);
            data_q.push_back(mem_data_o);
            n_writes <= n_writes + 1;
        end
        if (stall_en && mem_valid_o && n_writes == stall_at && stall_cnt < 10)
            stall_cnt <= stall_cnt + 1;
        if (sd_cmd_o == 2'd1) sec_q.push_back(sd_sector_o);
        if (sd_cmd_o != 2'd0) n_cmd <= n_cmd + 1;
        if (done_o) n_done <= n_done + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic start(input logic [31:0] sec, input logic [15:0] cnt, input logic [20:0] dst);
        start_i = 1'b1;
        start_sector_i = sec;
        sector_count_i = cnt;
        dest_addr_i = dst;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, output int cyc);
        cyc = 0;
        while (!done_o && cyc < limit) begin
            tick();
            cyc++;
        end
        chk({tag, " done"}, done_o, 1);
    endtask

    task automatic check_run(input string tag, input int b, input int n, input logic [31:0] dest);
        logic ok;
        logic [7:0] x;
        ok = 1'b1;
        chk({tag, " nwrites"}, n_writes - b, n);
        for (int i = 0; i < n; i++) begin
            x = 8'((4 * i) % 256);
            if (b + i >= addr_q.size() || addr_q[b + i] !== 21'(dest + i) ||
                data_q[b + i] !== {x + 8'd3, x + 8'd2, x + 8'd1, x})
                ok = 1'b0;
        end
        chk({tag, " contiguous"}, ok, 1);
    endtask

    initial begin
        int cyc, bw, bs, bd, bc;
        logic [20:0] a0;
        logic [31:0] d0;
        logic ok;
        stuck = 1'b0;
        stall_en = 1'b0;
        rst_i = 1'b1;
        start_i = 1'b0;
        start_sector_i = '0;
        sector_count_i = '0;
        dest_addr_i = '0;
        tick(2);
        chk("rst ctl", {busy_o, done_o, error_o, sd_cmd_o, mem_valid_o}, 0);
        chk("rst sector", sd_sector_o, 0);
        chk("rst addr", mem_addr_o, 0);
        chk("rst data", mem_data_o, 0);
        rst_i = 1'b0;
        tick();

        // one sector from sector 7 to 0x100
        bw = n_writes; bs = sec_q.size(); bd = n_done;
        start(7, 1, 21'h100);
        chk("t1 busy", busy_o, 1);
        wait_done("t1", 5000, cyc);
        chk("t1 busy at done", busy_o, 0);
        chk("t1 error", error_o, 0);
        tick();
        chk("t1 ncmd1", sec_q.size() - bs, 1);
        chk("t1 sector", sec_q[bs], 7);
        chk("t1 first addr", addr_q[bw], 21'h100);
        chk("t1 last addr", addr_q[bw + 127], 21'h17F);
        chk("t1 first data", data_q[bw], 32'h03020100);
        chk("t1 last data", data_q[bw + 127], 32'hFFFEFDFC);
        check_run("t1", bw, 128, 32'h100);
        chk("t1 ndone", n_done - bd, 1);

        // two sectors from sector 5, third write stalled 10 cycles
        bw = n_writes; bs = sec_q.size(); bd = n_done;
        stall_at = bw + 2;
        stall_en = 1'b1;
        start(5, 2, 21'h200);
        cyc = 0;
        while (!(mem_valid_o && n_writes == stall_at) && cyc < 3000) begin
            tick();
            cyc++;
        end
        chk("t2 stall reached", mem_valid_o, 1);
        a0 = mem_addr_o;
        d0 = mem_data_o;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!mem_valid_o || mem_addr_o !== a0 || mem_data_o !== d0 || sd_cmd_o == 2'd2)
                ok = 1'b0;
            tick();
        end
        chk("t2 stall addr", a0, 21'h202);
        chk("t2 stall data", d0, 32'h0B0A0908);
        chk("t2 stall held", ok, 1);
        wait_done("t2", 10000, cyc);
        stall_en = 1'b0;
        tick();
        chk("t2 ncmd1", sec_q.size() - bs, 2);
        chk("t2 sectors", {sec_q[bs], sec_q[bs + 1]}, {32'd5, 32'd6});
        check_run("t2", bw, 256, 32'h200);
        chk("t2 ndone", n_done - bd, 1);

        // zero sectors
        bw = n_writes; bc = n_cmd; bd = n_done;
        start(3, 0, 21'h300);
        chk("t3 done", done_o, 1);
        chk("t3 busy", busy_o, 0);
        tick();
        chk("t3 done pulse", done_o, 0);
        tick(10);
        chk("t3 no cmd", n_cmd - bc, 0);
        chk("t3 no write", n_writes - bw, 0);
        chk("t3 ndone", n_done - bd, 1);

        // card busy stuck high -> timeout
        stuck = 1'b1;
        bs = sec_q.size();
        start(4, 1, 21'h0);
        cyc = 0;
        while (!done_o && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("t4 timeout cycles", cyc, 100);
        chk("t4 error", error_o, 1);
        chk("t4 busy", busy_o, 0);
        tick();
        chk("t4 done pulse", done_o, 0);
        chk("t4 error sticky", error_o, 1);
        chk("t4 no read", sec_q.size() - bs, 0);
        stuck = 1'b0;

        // next start clears error; a start mid-load is ignored
        bw = n_writes; bs = sec_q.size(); bd = n_done;
        start(9, 1, 21'h400);
        chk("t5 error cleared", error_o, 0);
        tick(30);
        start(20, 3, 21'h800);
        wait_done("t5", 5000, cyc);
        tick();
        chk("t5 ncmd1", sec_q.size() - bs, 1);
        chk("t5 sector", sec_q[bs], 9);
        check_run("t5", bw, 128, 32'h400);
        chk("t5 ndone", n_done - bd, 1);

        // reset mid-sector, then a clean load
        bw = n_writes;
        start(3, 1, 21'h600);
        cyc = 0;
        while (n_writes < bw + 5 && cyc < 3000) begin
            tick();
            cyc++;
        end
        rst_i = 1'b1;
        tick();
        chk("t6 rst ctl", {busy_o, done_o, error_o, sd_cmd_o, mem_valid_o}, 0);
        chk("t6 rst sector", sd_sector_o, 0);
        chk("t6 rst addr", mem_addr_o, 0);
        chk("t6 rst data", mem_data_o, 0);
        rst_i = 1'b0;
        bw = n_writes; bc = n_cmd;
        tick(60);
        chk("t6 no writes after rst", n_writes - bw, 0);
        chk("t6 no cmd after rst", n_cmd - bc, 0);
        bs = sec_q.size(); bd = n_done;
        start(11, 1, 21'h10);
        wait_done("t6", 5000, cyc);
        tick();
        chk("t6 sector", sec_q[bs], 11);
        check_run("t6", bw, 128, 32'h10);
        chk("t6 ndone", n_done - bd, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
